icache_refill_ctrl: RTL and testbench

- Miss-handling sequencer for the direct-mapped instruction cache.
- Watches fetch lookups; on a miss, fetches the line from the next-level memory port as a burst.
- Writes each returned word into the cache via its write port, then releases fetch so the lookup is replayed and hits.
- Sits between fetch, the i-cache and the memory arbiter.

---
 rtl/icache_refill_ctrl.sv | 121 ++++++++++++
 tb/tb_icache_refill_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_refill_ctrl.sv
// I-cache miss sequencer: on a fetch miss, bursts the line in from memory and writes it into the cache.
// Optional hit/miss performance counters are enabled with `define ICACHE_REFILL_PERF_EN.
module icache_refill_ctrl #(
    parameter int LINE_WORDS = 4,
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 32
) (
    input  logic              CLK,
    input  logic              RESET,
`ifdef ICACHE_REFILL_PERF_EN
    output logic [CNT_W-1:0]  perf_hits,
    output logic [CNT_W-1:0]  perf_misses,
`endif
    input  logic              fetch_valid,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              fetch_redirect,
    input  logic              cache_read_hit,
    input  logic [31:0]       cache_read_data,
    output logic              fetch_instr_valid,
    output logic [31:0]       fetch_instr,
    output logic              fetch_stall,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              cache_write_request,
    output logic [ADDR_W-1:0] cache_write_address,
    output logic [31:0]       cache_write_data
);

    localparam int OFF = $clog2(LINE_WORDS) + 2;
    localparam int CW  = $clog2(LINE_WORDS) + 1;
    localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << OFF) - ADDR_W'(1));
    localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_t;

    state_t            state, state_next;
    logic [CW-1:0]     beat_cnt;
    logic [ADDR_W-1:0] miss_base;
    logic              miss_capture;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            beat_cnt  <= '0;
            miss_base <= '0;
        end else begin
            state <= state_next;
            if (miss_capture)
                miss_base <= fetch_pc & LINE_MASK;
            if (state == REQ && mem_gnt)
                beat_cnt <= '0;
            else if (state == FILL && mem_rvalid)
                beat_cnt <= beat_cnt + CW'(1);
        end
    end

    always_comb begin
        state_next          = state;
        miss_capture        = 1'b0;
        fetch_instr_valid   = 1'b0;
        fetch_instr         = '0;
        fetch_stall         = 1'b0;
        mem_req             = 1'b0;
        mem_addr            = '0;
        cache_write_request = 1'b0;
        cache_write_address = '0;
        cache_write_data    = '0;
        unique case (state)
            IDLE: begin
                fetch_instr_valid = fetch_valid & cache_read_hit;
                fetch_instr       = fetch_instr_valid ? cache_read_data : 32'h0;
                fetch_stall       = fetch_valid & ~cache_read_hit;
                // A redirecting fetch abandons this PC, so its miss is not worth refilling.
                if (fetch_valid && !cache_read_hit && !fetch_redirect) begin
                    miss_capture = 1'b1;
                    state_next   = REQ;
                end
            end
            REQ: begin
                fetch_stall = 1'b1;
                mem_req     = 1'b1;
                mem_addr    = miss_base;
                if (mem_gnt)
                    state_next = FILL;
            end
            FILL: begin
                fetch_stall = 1'b1;
                if (mem_rvalid) begin
                    cache_write_request = 1'b1;
                    cache_write_address = miss_base + ADDR_W'({beat_cnt, 2'b00});
                    cache_write_data    = mem_rdata;
                    if (beat_cnt == LAST_BEAT)
                        state_next = DONE;
                end
            end
            DONE: begin
                fetch_stall = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef ICACHE_REFILL_PERF_EN
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            perf_hits   <= '0;
            perf_misses <= '0;
        end else begin
            if (state == IDLE && fetch_instr_valid && perf_hits != '1)
                perf_hits <= perf_hits + CNT_W'(1);
            if (miss_capture && perf_misses != '1)
                perf_misses <= perf_misses + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Directed bench for icache_refill_ctrl: table of idle-state vectors plus hand-written refill sequences.
module tb_icache_refill_ctrl;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        fetch_valid = 0, fetch_redirect = 0, cache_read_hit = 0;
    logic [31:0] fetch_pc = 0, cache_read_data = 0;
    logic        fetch_instr_valid, fetch_stall, mem_req;
    logic [31:0] fetch_instr, mem_addr;
    logic        mem_gnt = 0, mem_rvalid = 0;
    logic [31:0] mem_rdata = 0;
    logic        cache_write_request;
    logic [31:0] cache_write_address, cache_write_data;
`ifdef ICACHE_REFILL_PERF_EN
    logic [3:0]  perf_hits, perf_misses;
`endif

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    icache_refill_ctrl #(.LINE_WORDS(4), .ADDR_W(32), .CNT_W(4)) dut (
        .CLK(CLK), .RESET(RESET),
`ifdef ICACHE_REFILL_PERF_EN
        .perf_hits(perf_hits), .perf_misses(perf_misses),
`endif
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc), .fetch_redirect(fetch_redirect),
        .cache_read_hit(cache_read_hit), .cache_read_data(cache_read_data),
        .fetch_instr_valid(fetch_instr_valid), .fetch_instr(fetch_instr), .fetch_stall(fetch_stall),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .cache_write_request(cache_write_request), .cache_write_address(cache_write_address),
        .cache_write_data(cache_write_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Full miss -> refill -> replay-hit sequence. gap_before inserts one idle cycle before that beat index;
    // redirect_from raises fetch_redirect from that beat index onward.
    task automatic refill(input logic [31:0] pc, input logic [31:0] base,
                          input int gap_before, input int redirect_from);
        fetch_valid = 1; fetch_pc = pc; cache_read_hit = 0; fetch_redirect = 0;
        #1;
        chk("miss_stall", {31'b0, fetch_stall}, 1);
        chk("miss_no_instr", {31'b0, fetch_instr_valid}, 0);
        chk("miss_no_req_yet", {31'b0, mem_req}, 0);
        step();
        chk("req_asserted", {31'b0, mem_req}, 1);
        chk("req_addr", mem_addr, base);
        step();
        chk("req_held", {31'b0, mem_req}, 1);
        chk("req_addr_held", mem_addr, base);
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        #1;
        chk("req_drop_after_gnt", {31'b0, mem_req}, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == gap_before) begin
                mem_rvalid = 0;
                #1;
                chk("gap_no_write", {31'b0, cache_write_request}, 0);
                chk("gap_stall", {31'b0, fetch_stall}, 1);
                step();
            end
            if (redirect_from >= 0 && i >= redirect_from) fetch_redirect = 1;
            mem_rvalid = 1;
            mem_rdata = 32'h11 * (i + 1);
            #1;
            chk("beat_write", {31'b0, cache_write_request}, 1);
            chk("beat_addr", cache_write_address, base + 32'(4 * i));
            chk("beat_data", cache_write_data, 32'h11 * (i + 1));
            chk("beat_stall", {31'b0, fetch_stall}, 1);
            step();
        end
        mem_rvalid = 0;
        #1;
        chk("done_stall", {31'b0, fetch_stall}, 1);
        chk("done_no_write", {31'b0, cache_write_request}, 0);
        chk("done_no_req", {31'b0, mem_req}, 0);
        chk("done_no_instr", {31'b0, fetch_instr_valid}, 0);
        step();
        fetch_redirect = 0;
        fetch_pc = pc + 32'h40;
        cache_read_hit = 1;
        cache_read_data = 32'hCAFE0001;
        #1;
        chk("replay_valid", {31'b0, fetch_instr_valid}, 1);
        chk("replay_instr", fetch_instr, 32'hCAFE0001);
        chk("replay_stall", {31'b0, fetch_stall}, 0);
        step();
        fetch_valid = 0; cache_read_hit = 0;
    endtask

    typedef struct {
        logic        valid, hit, redirect, rvalid, gnt;
        logic [31:0] data;
        logic        exp_valid;
        logic [31:0] exp_instr;
        logic        exp_stall;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{1, 1, 0, 0, 0, 32'h00A00093, 1, 32'h00A00093, 0};
        vecs[1] = '{0, 1, 0, 0, 0, 32'hDEADBEEF, 0, 32'h0,        0};
        vecs[2] = '{0, 0, 0, 0, 0, 32'h55555555, 0, 32'h0,        0};
        vecs[3] = '{1, 1, 1, 0, 0, 32'h12345678, 1, 32'h12345678, 0};
        vecs[4] = '{1, 0, 1, 0, 0, 32'h87654321, 0, 32'h0,        1};
        vecs[5] = '{1, 1, 0, 1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0};
        vecs[6] = '{0, 0, 0, 1, 1, 32'hA5A5A5A5, 0, 32'h0,        0};

        // Reset held for three cycles
        RESET = 0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_mem_req", {31'b0, mem_req}, 0);
        chk("rst_write", {31'b0, cache_write_request}, 0);
        RESET = 1;
        #1;
        chk("rel_mem_req", {31'b0, mem_req}, 0);
        chk("rel_write", {31'b0, cache_write_request}, 0);
        chk("rel_instr_valid", {31'b0, fetch_instr_valid}, 0);
        chk("rel_stall", {31'b0, fetch_stall}, 0);
        chk("rel_mem_addr", mem_addr, 0);
        step();

        // Idle-state vectors; none of them may launch a refill
        for (int k = 0; k < 7; k++) begin
            fetch_valid = vecs[k].valid; cache_read_hit = vecs[k].hit;
            fetch_redirect = vecs[k].redirect; cache_read_data = vecs[k].data;
            mem_rvalid = vecs[k].rvalid; mem_gnt = vecs[k].gnt;
            fetch_pc = 32'h0000_1000 + 32'(k * 4);
            #1;
            chk($sformatf("vec%0d_valid", k), {31'b0, fetch_instr_valid}, {31'b0, vecs[k].exp_valid});
            chk($sformatf("vec%0d_instr", k), fetch_instr, vecs[k].exp_instr);
            chk($sformatf("vec%0d_stall", k), {31'b0, fetch_stall}, {31'b0, vecs[k].exp_stall});
            chk($sformatf("vec%0d_no_write", k), {31'b0, cache_write_request}, 0);
            step();
            fetch_valid = 0; fetch_redirect = 0; mem_rvalid = 0; mem_gnt = 0;
            #1;
            chk($sformatf("vec%0d_stay_idle", k), {31'b0, mem_req | fetch_stall}, 0);
            $display("vector %0d applied", k);
        end
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_hits_3", {28'b0, perf_hits}, 3);
        chk("perf_misses_0", {28'b0, perf_misses}, 0);
`endif

        refill(32'h0000_1234, 32'h0000_1230, 2, -1);
        $display("refill 0x1234 done");
`ifdef ICACHE_REFILL_PERF_EN
        chk("perf_misses_1", {28'b0, perf_misses}, 1);
`endif
        refill(32'h0000_2008, 32'h0000_2000, -1, 1);
        $display("refill with redirect done");
        refill(32'hFFFF_FFFC, 32'hFFFF_FFF0, -1, -1);
        $display("refill wrap-around done");

        // Reset during a burst, then stray beats after release
        fetch_valid = 1; fetch_pc = 32'h0000_3004; cache_read_hit = 0;
        step();
        fetch_valid = 0;
        mem_gnt = 1;
        step();
        mem_gnt = 0;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1; mem_rdata = 32'hBEEF0000 + 32'(i);
            #1;
            chk("pre_rst_write", {31'b0, cache_write_request}, 1);
            step();
        end
        #2;
        RESET = 0;
        #1;
        chk("midrst_write", {31'b0, cache_write_request}, 0);
        chk("midrst_req", {31'b0, mem_req}, 0);
        chk("midrst_stall", {31'b0, fetch_stall}, 0);
        step();
        step();
        RESET = 1;
        for (int i = 0; i < 2; i++) begin
            mem_rvalid = 1; mem_rdata = 32'hBAD00000 + 32'(i);
            #1;
            chk("stray_no_write", {31'b0, cache_write_request}, 0);
            chk("stray_no_stall", {31'b0, fetch_stall}, 0);
            step();
        end
        mem_rvalid = 0;
        fetch_valid = 1; cache_read_hit = 1; cache_read_data = 32'h00B00113;
        #1;
        chk("post_rst_hit", {31'b0, fetch_instr_valid}, 1);
        chk("post_rst_instr", fetch_instr, 32'h00B00113);
        $display("reset mid-burst sequence done");
`ifdef ICACHE_REFILL_PERF_EN
        repeat (20) step();
        chk("perf_hits_sat", {28'b0, perf_hits}, 32'hF);
`endif
        step();
        fetch_valid = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
